decode_stage_seq: RTL and testbench
===================================

Name: decode_stage_seq

Overview:
Registered, parametrised instruction-decode stage between the fetch pipe register and the register-read stage of the 16-bit LCA pipeline.
- Decodes one instruction per accepted handshake into register addresses, immediates and write-enable controls.
- Computes the PC-relative target.
- Expands LM/SM into one micro-op per selected register through an internal sequencer, back-pressuring fetch while it runs.
- Supports flush from branch resolution.

Parameters:
DW, 16, data/PC/immediate width (must be >= 16)
RAW, 3, register address width
MASK_W, 8, LM/SM register-mask width (IR[MASK_W-1:0]); must equal 2**RAW

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
flush  in  1  synchronous kill of current output and any LM/SM sequence
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage accepts in_pc/in_ir this cycle
in_pc  in  DW  PC of instruction
in_ir  in  16  instruction word
out_valid  out  1  decoded micro-op valid
out_ready  in  1  downstream accepts micro-op
out_pc  out  DW  PC of the decoded instruction
pc_imm  out  DW  branch/jump target
ra1, ra2, wa  out  RAW each  read addr 1, read addr 2, write addr
sext_imm6  out  DW  sign-extended IR[5:0]
imm970  out  DW  {IR[8:0], DW-9 zeros}
mex1, mex2  out  1 each  ALU operand selects (0 = RF out, 1 = immediate)
wccr, wmem, wrf  out  1 each  active-low enables: 0 = write CCR / memory / register file
uop_idx  out  RAW  LM/SM micro-op ordinal (0 for other instructions)
lmsm_last  out  1  final micro-op of an instruction (1 for non-LM/SM)

Behaviour:
- Reset (async): out_valid=0; all data outputs 0; wccr=wmem=wrf=1; mex1=mex2=0; lmsm_last=1; state=PASS. in_ready is combinational and is 1 in PASS when the output is empty or being consumed.
- Output register advances when out_ready=1 or out_valid=0 ("advance"). Latency is 1 cycle from accept to out_valid. Outputs hold stable while out_valid=1 and out_ready=0.
- PASS state: accept = in_valid & in_ready. Decode by IR[15:12]:
  - 0000 ADD/ADC/ADZ and 0010 NAND: ra1=IR[11:9], ra2=IR[8:6], wa=IR[5:3], wccr=0, wrf=0.
  - 0001 ADI: ra1=IR[11:9], wa=IR[8:6], mex2=1, wccr=0, wrf=0.
  - 0011 LHI: wa=IR[11:9], wrf=0.
  - 0100 LW: wa=IR[11:9], ra2=IR[8:6], mex2=1, wrf=0.
  - 0101 SW: ra1=IR[11:9], ra2=IR[8:6], mex2=1, wmem=0.
  - 1100 BEQ: ra1=IR[11:9], ra2=IR[8:6].
  - 1000 JAL: wa=IR[11:9], wrf=0.
  - 1001 JLR: wa=IR[11:9], ra2=IR[8:6], wrf=0.
  - Other opcodes: NOP, all enables 1.
  - Unlisted fields are 0.
- pc_imm = in_pc + sext(IR[8:0]) for opcode 1000, otherwise in_pc + sext(IR[5:0]). Result is modulo 2**DW (wraps).
- LM (0110) / SM (0111): on accept, latch IR and PC, mask = IR[MASK_W-1:0], enter SEQ.
  - SEQ emits one micro-op per set mask bit, lowest index first.
  - Each micro-op has ra1 = base IR[11:9] and uop_idx = count of previously emitted micro-ops.
  - LM micro-op: wa = bit index, wrf=0, wmem=1.
  - SM micro-op: ra2 = bit index, wmem=0, wrf=1.
  - The emitted bit is cleared on advance.
  - lmsm_last=1 on the micro-op whose emitted bit is the last set bit; after it advances, state returns to PASS.
  - in_ready=0 throughout SEQ.
- Mask = 0: a single NOP micro-op (wrf=wmem=1) with lmsm_last=1; no SEQ cycles.
- flush (priority over accept and advance): next edge out_valid=0, state=PASS, mask cleared. in_ready=0 during the flush cycle, so nothing is accepted.
- Reset mid-sequence aborts immediately; no further micro-ops are emitted.

Test Plan:
- Reset asserted mid-run -> out_valid=0, wmem=wrf=wccr=1, in_ready=1 after release.
- ADD IR=0x0298 (RA=1,RB=2,RC=3), PC=0x0010 -> next cycle ra1=1, ra2=2, wa=3, wrf=0, wccr=0, wmem=1, lmsm_last=1.
- JAL IR=0x85FF (RA=2, imm9=-1), PC=0x0020 -> wa=2, pc_imm=0x001F. ADI imm6=0x3F at PC=0xFFFF -> pc_imm=0xFFFE (wrap), sext_imm6=0xFFFF.
- LM IR=0x6A25 (base=5, mask=0x25) with out_ready=1 -> 3 micro-ops wa=0,2,5, uop_idx=0,1,2, lmsm_last only on the third; in_ready=0 until the third advances.
- SM mask=0x81 with out_ready low for 2 cycles on the first micro-op -> outputs held; then ra2=0 followed by ra2=7, wmem=0 on both.
- flush asserted during the second LM micro-op -> out_valid=0 next cycle, remaining micro-ops never appear; the next instruction is accepted the cycle after.

Source files
------------

// File: rtl/decode_stage_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_stage_seq : registered LCA decode stage with LM/SM micro-op sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
module decode_stage_seq #(
   parameter int DW     = 16,
   parameter int RAW    = 3,
   parameter int MASK_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_pc,
   input  logic [15:0]     in_ir,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_pc,
   output logic [DW-1:0]   pc_imm,
   output logic [RAW-1:0]  ra1,
   output logic [RAW-1:0]  ra2,
   output logic [RAW-1:0]  wa,
   output logic [DW-1:0]   sext_imm6,
   output logic [DW-1:0]   imm970,
   output logic            mex1,
   output logic            mex2,
   output logic            wccr,
   output logic            wmem,
   output logic            wrf,
   output logic [RAW-1:0]  uop_idx,
   output logic            lmsm_last
);

   typedef enum logic [0:0] {S_PASS = 1'b0, S_SEQ = 1'b1} state_t;

   state_t              r_state, w_state_nxt;
   logic [15:0]         r_ir;
   logic [DW-1:0]       r_pc;
   logic [MASK_W-1:0]   r_mask;
   logic [RAW-1:0]      r_cnt;

   logic                w_adv, w_accept, w_load, w_is_lmsm;
   logic [15:0]         w_ir;
   logic [DW-1:0]       w_pc, w_sext6, w_sext9, w_imm970, w_pc_imm;
   logic [MASK_W-1:0]   w_mask, w_onehot, w_rem;
   logic [RAW-1:0]      w_cnt, w_bit;
   logic [3:0]          w_op;
   logic [RAW-1:0]      w_ra1, w_ra2, w_wa, w_idx;
   logic                w_mex1, w_mex2, w_wccr, w_wmem, w_wrf, w_last;

   assign w_adv    = out_ready | ~out_valid;
   assign in_ready = (r_state == S_PASS) & w_adv & ~flush;
   assign w_accept = in_valid & in_ready;

   // In SEQ the decoder works on the latched LM/SM word instead of fetch
   assign w_ir   = (r_state == S_SEQ) ? r_ir   : in_ir;
   assign w_pc   = (r_state == S_SEQ) ? r_pc   : in_pc;
   assign w_mask = (r_state == S_SEQ) ? r_mask : in_ir[MASK_W-1:0];
   assign w_cnt  = (r_state == S_SEQ) ? r_cnt  : '0;
   assign w_op   = w_ir[15:12];
   assign w_is_lmsm = (w_op == 4'b0110) | (w_op == 4'b0111);

   assign w_load = w_accept | ((r_state == S_SEQ) & (r_mask != '0) & w_adv & ~flush);

   always_comb begin
      w_bit = '0;
      for (int i = MASK_W - 1; i >= 0; i--) begin
         if (w_mask[i]) w_bit = RAW'(i);
      end
   end

   assign w_onehot = {{(MASK_W-1){1'b0}}, 1'b1} << w_bit;
   assign w_rem    = w_mask & ~w_onehot;

   assign w_sext6  = {{(DW-6){w_ir[5]}}, w_ir[5:0]};
   assign w_sext9  = {{(DW-9){w_ir[8]}}, w_ir[8:0]};
   assign w_imm970 = {w_ir[8:0], {(DW-9){1'b0}}};
   assign w_pc_imm = w_pc + ((w_op == 4'b1000) ? w_sext9 : w_sext6);

   always_comb begin
      w_ra1  = '0;
      w_ra2  = '0;
      w_wa   = '0;
      w_idx  = '0;
      w_mex1 = 1'b0;
      w_mex2 = 1'b0;
      w_wccr = 1'b1;
      w_wmem = 1'b1;
      w_wrf  = 1'b1;
      w_last = 1'b1;
      case (w_op)
         4'b0000, 4'b0010: begin
            w_ra1 = w_ir[11:9]; w_ra2 = w_ir[8:6]; w_wa = w_ir[5:3];
            w_wccr = 1'b0; w_wrf = 1'b0;
         end
         4'b0001: begin
            w_ra1 = w_ir[11:9]; w_wa = w_ir[8:6];
            w_mex2 = 1'b1; w_wccr = 1'b0; w_wrf = 1'b0;
         end
         4'b0011: begin
            w_wa = w_ir[11:9]; w_wrf = 1'b0;
         end
         4'b0100: begin
            w_wa = w_ir[11:9]; w_ra2 = w_ir[8:6]; w_mex2 = 1'b1; w_wrf = 1'b0;
         end
         4'b0101: begin
            w_ra1 = w_ir[11:9]; w_ra2 = w_ir[8:6]; w_mex2 = 1'b1; w_wmem = 1'b0;
         end
         4'b1100: begin
            w_ra1 = w_ir[11:9]; w_ra2 = w_ir[8:6];
         end
         4'b1000: begin
            w_wa = w_ir[11:9]; w_wrf = 1'b0;
         end
         4'b1001: begin
            w_wa = w_ir[11:9]; w_ra2 = w_ir[8:6]; w_wrf = 1'b0;
         end
         4'b0110, 4'b0111: begin
            w_ra1 = w_ir[11:9];
            w_idx = w_cnt;
            // an empty mask degenerates into a single NOP micro-op
            if (w_mask != '0) begin
               w_last = (w_rem == '0);
               if (w_op == 4'b0110) begin
                  w_wa  = w_bit;
                  w_wrf = 1'b0;
               end else begin
                  w_ra2  = w_bit;
                  w_wmem = 1'b0;
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = S_PASS;
      end else begin
         case (r_state)
            S_PASS: if (w_accept && w_is_lmsm && (w_mask != '0)) w_state_nxt = S_SEQ;
            S_SEQ:  if (w_adv && (r_mask == '0)) w_state_nxt = S_PASS;
            default: w_state_nxt = S_PASS;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_PASS;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_pc    <= '0;
         pc_imm    <= '0;
         ra1       <= '0;
         ra2       <= '0;
         wa        <= '0;
         sext_imm6 <= '0;
         imm970    <= '0;
         mex1      <= 1'b0;
         mex2      <= 1'b0;
         wccr      <= 1'b1;
         wmem      <= 1'b1;
         wrf       <= 1'b1;
         uop_idx   <= '0;
         lmsm_last <= 1'b1;
         r_ir      <= '0;
         r_pc      <= '0;
         r_mask    <= '0;
         r_cnt     <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         r_mask    <= '0;
         r_cnt     <= '0;
      end else if (w_load) begin
         out_valid <= 1'b1;
         out_pc    <= w_pc;
         pc_imm    <= w_pc_imm;
         ra1       <= w_ra1;
         ra2       <= w_ra2;
         wa        <= w_wa;
         sext_imm6 <= w_sext6;
         imm970    <= w_imm970;
         mex1      <= w_mex1;
         mex2      <= w_mex2;
         wccr      <= w_wccr;
         wmem      <= w_wmem;
         wrf       <= w_wrf;
         uop_idx   <= w_idx;
         lmsm_last <= w_last;
         if (w_is_lmsm) begin
            r_ir   <= w_ir;
            r_pc   <= w_pc;
            r_mask <= w_rem;
            r_cnt  <= w_cnt + RAW'(1);
         end
      end else if (w_adv) begin
         out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_seq.sv
`default_nettype none
// tb_decode_stage_seq : directed self-checking bench for decode_stage_seq
// Rev 1.0
module tb_decode_stage_seq;

   logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [15:0] in_pc, in_ir, out_pc, pc_imm, sext_imm6, imm970;
   logic [2:0]  ra1, ra2, wa, uop_idx;
   logic        mex1, mex2, wccr, wmem, wrf, lmsm_last;

   int n_checks = 0;
   int n_errors = 0;

   decode_stage_seq #(.DW(16), .RAW(3), .MASK_W(8)) u_dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ir(in_ir),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .pc_imm(pc_imm), .ra1(ra1), .ra2(ra2), .wa(wa),
      .sext_imm6(sext_imm6), .imm970(imm970), .mex1(mex1), .mex2(mex2),
      .wccr(wccr), .wmem(wmem), .wrf(wrf), .uop_idx(uop_idx), .lmsm_last(lmsm_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] pc, input logic [15:0] ir);
      in_valid = 1'b1;
      in_pc    = pc;
      in_ir    = ir;
      #1 chk("accept_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      clk = 0; reset = 1; flush = 0; in_valid = 0; in_pc = 0; in_ir = 0; out_ready = 1;
      repeat (2) tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_wrf", wrf, 1);
      chk("rst_wmem", wmem, 1);
      chk("rst_wccr", wccr, 1);
      chk("rst_last", lmsm_last, 1);
      reset = 0;
      #1 chk("rst_in_ready", in_ready, 1);

      send(16'h0010, 16'h0298);   // ADD r3 = r1 + r2
      chk("add_valid", out_valid, 1);
      chk("add_ra1", ra1, 1);
      chk("add_ra2", ra2, 2);
      chk("add_wa", wa, 3);
      chk("add_wrf", wrf, 0);
      chk("add_wccr", wccr, 0);
      chk("add_wmem", wmem, 1);
      chk("add_last", lmsm_last, 1);
      chk("add_pc", out_pc, 16'h0010);

      send(16'h0020, 16'h85FF);   // JAL r2, -1
      chk("jal_wa", wa, 2);
      chk("jal_pcimm", pc_imm, 16'h001F);
      chk("jal_wrf", wrf, 0);
      chk("jal_imm970", imm970, 16'hFF80);

      send(16'hFFFF, 16'h103F);   // ADI imm6=-1 at PC wrap point
      chk("adi_pcimm", pc_imm, 16'hFFFE);
      chk("adi_sext", sext_imm6, 16'hFFFF);
      chk("adi_mex2", mex2, 1);
      chk("adi_wccr", wccr, 0);

      send(16'h0030, 16'h6A00);   // LM with empty mask
      chk("lm0_valid", out_valid, 1);
      chk("lm0_wrf", wrf, 1);
      chk("lm0_wmem", wmem, 1);
      chk("lm0_last", lmsm_last, 1);
      chk("lm0_ready", in_ready, 1);

      send(16'h0040, 16'h6A25);   // LM base r5, mask 0x25
      chk("lm_wa0", wa, 0);
      chk("lm_idx0", uop_idx, 0);
      chk("lm_last0", lmsm_last, 0);
      chk("lm_ra1", ra1, 5);
      chk("lm_wrf0", wrf, 0);
      chk("lm_wmem0", wmem, 1);
      chk("lm_rdy0", in_ready, 0);
      tick();
      chk("lm_wa1", wa, 2);
      chk("lm_idx1", uop_idx, 1);
      chk("lm_last1", lmsm_last, 0);
      chk("lm_rdy1", in_ready, 0);
      tick();
      chk("lm_wa2", wa, 5);
      chk("lm_idx2", uop_idx, 2);
      chk("lm_last2", lmsm_last, 1);
      chk("lm_rdy2", in_ready, 0);
      tick();
      chk("lm_done_valid", out_valid, 0);
      chk("lm_done_ready", in_ready, 1);

      send(16'h0050, 16'h7681);   // SM base r3, mask 0x81
      chk("sm_ra2_0", ra2, 0);
      chk("sm_ra1", ra1, 3);
      chk("sm_wmem0", wmem, 0);
      chk("sm_wrf0", wrf, 1);
      out_ready = 0;
      tick();
      chk("sm_hold_valid", out_valid, 1);
      chk("sm_hold_ra2", ra2, 0);
      tick();
      chk("sm_hold_idx", uop_idx, 0);
      chk("sm_hold_ra2b", ra2, 0);
      chk("sm_hold_ready", in_ready, 0);
      out_ready = 1;
      tick();
      chk("sm_ra2_1", ra2, 7);
      chk("sm_wmem1", wmem, 0);
      chk("sm_last1", lmsm_last, 1);
      chk("sm_idx1", uop_idx, 1);
      tick();
      chk("sm_done_valid", out_valid, 0);

      send(16'h0060, 16'h6A25);   // LM again, flushed on its second micro-op
      chk("fl_wa0", wa, 0);
      tick();
      chk("fl_wa1", wa, 2);
      flush = 1; in_valid = 1; in_pc = 16'h0070; in_ir = 16'h0298;
      #1 chk("fl_ready", in_ready, 0);
      tick();
      flush = 0;
      chk("fl_valid", out_valid, 0);
      #1 chk("fl_after_ready", in_ready, 1);
      tick();
      in_valid = 0;
      chk("fl_next_valid", out_valid, 1);
      chk("fl_next_wa", wa, 3);
      chk("fl_next_pc", out_pc, 16'h0070);
      chk("fl_next_last", lmsm_last, 1);
      tick();
      chk("fl_no_stale", out_valid, 0);

      send(16'h0080, 16'h6A25);   // reset in the middle of an LM sequence
      tick();
      reset = 1;
      #1 chk("mr_valid", out_valid, 0);
      chk("mr_wmem", wmem, 1);
      chk("mr_wrf", wrf, 1);
      chk("mr_wccr", wccr, 1);
      tick();
      reset = 0;
      #1 chk("mr_ready", in_ready, 1);
      tick();
      chk("mr_no_uop", out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
